uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter (load/din/busy interface) between `N_REQ` byte-stream requesters. It locks the transmitter to one requester for a whole packet, which ends on the byte flagged `last`. It optionally prefixes each packet with a requester-ID header byte, and paces bytes using the transmitter's `tx_busy`. It sits between the test-result sources and the transmitter, and is the only driver of the transmitter's `load` and `din`.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_sched.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - ID_W / CNT_W  : requester-index and busy-timeout counter widths
//   - BUSY_TO_DEF   : default busy-rise timeout in clk cycles
//   - HDR_MAGIC     : upper five bits of the per-packet header byte
//   - state_t       : scheduler FSM state encoding
//   - hdr_byte()    : builds the header byte for a requester index
package uart_pkg;

    localparam int         ID_W        = 3;
    localparam int         CNT_W       = 10;
    localparam int         BUSY_TO_DEF = 1023;
    localparam logic [4:0] HDR_MAGIC   = 5'b10100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HDR       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant. The search starts at i_ptr+1 (mod N_REQ)
// and wraps, so the requester at i_ptr has the lowest priority.
// Ports:
//   i_req     [N_REQ-1:0] : request vector
//   i_ptr     [ID_W-1:0]  : index of the most recently served requester
//   o_gnt     [N_REQ-1:0] : one-hot grant (all zero when no request)
//   o_gnt_idx [ID_W-1:0]  : encoded index of the granted requester
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_idx
);

    always_comb begin
        o_gnt_idx = '0;
        o_gnt     = '0;
        // Walk offsets from farthest to nearest so the nearest requester
        // after i_ptr is the one left standing.
        for (int k = N_REQ; k >= 1; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (i_req[j] && (j == ((int'(i_ptr) + k) % N_REQ))) begin
                    o_gnt_idx = j[ID_W-1:0];
                end
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            o_gnt[j] = (|i_req) && (o_gnt_idx == j[ID_W-1:0]);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Shares one UART transmitter (load/din/busy) between N_REQ byte-stream
// requesters. A requester is locked for a whole packet (ended by the byte
// flagged last); an optional header byte {HDR_MAGIC, id} precedes each
// packet. Bytes are paced by the transmitter's tx_busy.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req   [N_REQ-1:0]   : per-requester byte valid, held until acked
//   data  [8*N_REQ-1:0] : byte of requester i at data[8i+7:8i]
//   last  [N_REQ-1:0]   : presented byte ends the packet
//   ack   [N_REQ-1:0]   : one-cycle pulse, byte taken
//   tx_load             : one-cycle load pulse to the transmitter
//   tx_din [7:0]        : registered byte to the transmitter
//   tx_busy             : transmitter busy
//   active              : a packet is locked
//   cur_id [ID_W-1:0]   : locked requester index (held when idle)
//   tx_err              : sticky busy-timeout flag
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HDR_EN  = 1,
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data,
    input  logic [N_REQ-1:0]   last,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_load,
    output logic [7:0]         tx_din,
    input  logic               tx_busy,
    output logic               active,
    output logic [ID_W-1:0]    cur_id,
    output logic               tx_err
);

    localparam logic [CNT_W-1:0] LP_BUSY_TO = CNT_W'(BUSY_TO);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_cur_id;
    logic [7:0]        r_din;
    logic              r_pkt_end;
    logic              r_hdr_flag;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_any_req;
    logic [ID_W-1:0]   w_sel_id;
    logic [7:0]        w_sel_data;
    logic              w_cur_req;
    logic              w_cur_last;
    logic              w_to_hit;
    logic              w_grant;
    logic              w_go_hdr;
    logic              w_go_load;
    logic              w_release;
    logic              w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_any_req = |w_gnt;
    assign w_to_hit  = (r_cnt >= LP_BUSY_TO);

    // In IDLE (header disabled) the byte comes from the requester being
    // granted this cycle; otherwise from the locked requester.
    assign w_sel_id = (r_state == ST_IDLE) ? w_gnt_idx : r_cur_id;

    always_comb begin
        w_sel_data = '0;
        w_cur_req  = 1'b0;
        w_cur_last = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_sel_id == j[ID_W-1:0]) begin
                w_sel_data = data[8*j +: 8];
            end
            if (r_cur_id == j[ID_W-1:0]) begin
                w_cur_req  = req[j];
                w_cur_last = last[j];
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_go_hdr  = 1'b0;
        w_go_load = 1'b0;
        w_release = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant = 1'b1;
                    if (HDR_EN != 0) begin
                        w_next   = ST_HDR;
                        w_go_hdr = 1'b1;
                    end else begin
                        w_next    = ST_LOAD;
                        w_go_load = 1'b1;
                    end
                end
            end
            ST_HDR:  w_next = ST_WAIT_BUSY;
            ST_LOAD: w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // A busy rise in the same cycle as the limit wins.
                if (tx_busy) begin
                    w_next = ST_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                    w_release = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (!r_hdr_flag && r_pkt_end) begin
                        w_next    = ST_IDLE;
                        w_release = 1'b1;
                    end else if (w_cur_req) begin
                        w_next    = ST_LOAD;
                        w_go_load = 1'b1;
                    end else begin
                        w_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_cur_req) begin
                    w_next    = ST_LOAD;
                    w_go_load = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= ID_W'(N_REQ - 1);
            r_cur_id   <= '0;
            r_din      <= 8'hFF;
            r_pkt_end  <= 1'b0;
            r_hdr_flag <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cur_id <= w_gnt_idx;
            end
            if (w_release) begin
                r_ptr <= r_cur_id;
            end
            // tx_din is loaded one cycle ahead so it is registered and
            // already valid in the cycle tx_load is high.
            if (w_go_hdr) begin
                r_din <= hdr_byte(w_gnt_idx);
            end else if (w_go_load) begin
                r_din <= w_sel_data;
            end
            if (r_state == ST_HDR) begin
                r_hdr_flag <= 1'b1;
            end else if (r_state == ST_LOAD) begin
                r_hdr_flag <= 1'b0;
                r_pkt_end  <= w_cur_last;
            end
            if ((r_state == ST_HDR) || (r_state == ST_LOAD)) begin
                r_cnt <= '0;
            end else if ((r_state == ST_WAIT_BUSY) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs decode straight from state so reset removes tx_load at once.
    always_comb begin
        ack = '0;
        for (int j = 0; j < N_REQ; j++) begin
            ack[j] = (r_state == ST_LOAD) && (r_cur_id == j[ID_W-1:0]);
        end
    end

    assign tx_load = (r_state == ST_HDR) || (r_state == ST_LOAD);
    assign tx_din  = r_din;
    assign active  = (r_state != ST_IDLE);
    assign cur_id  = r_cur_id;
    assign tx_err  = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main DUT: header on, short timeout
    logic [3:0]  req, last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        tx_load, tx_busy, active, tx_err;
    logic [7:0]  tx_din;
    logic [2:0]  cur_id;

    // Second DUT: header off
    logic [3:0]  req2, last2;
    logic [31:0] data2;
    logic [3:0]  ack2;
    logic        tx_load2, tx_busy2, active2, tx_err2;
    logic [7:0]  tx_din2;
    logic [2:0]  cur_id2;

    always #5 clk = ~clk;

    uart_tx_sched #(.N_REQ(4), .HDR_EN(1), .BUSY_TO(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .last(last),
        .ack(ack), .tx_load(tx_load), .tx_din(tx_din), .tx_busy(tx_busy),
        .active(active), .cur_id(cur_id), .tx_err(tx_err)
    );

    uart_tx_sched #(.N_REQ(4), .HDR_EN(0), .BUSY_TO(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .data(data2), .last(last2),
        .ack(ack2), .tx_load(tx_load2), .tx_din(tx_din2), .tx_busy(tx_busy2),
        .active(active2), .cur_id(cur_id2), .tx_err(tx_err2)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;

    // Requester scripts
    logic [7:0] sdat  [4][8];
    logic       slast [4][8];
    int         slen  [4];
    int         sidx  [4];
    int         shold [4];
    logic       sen   [4];

    // Transmitter models
    logic dead;
    int   bcnt, bcnt2;

    // Logs and per-cycle snapshots (taken on the falling edge)
    logic [7:0] lg  [32];
    logic [7:0] lg2 [32];
    int         n_lg, n_lg2;
    int         ackc [4];
    int         a2c;
    logic       s_load, s_active, s_err, s_load2;
    logic [7:0] s_din, s_din2;
    logic [2:0] s_cur;
    logic [3:0] s_ack, s_ack2;
    logic [7:0] exq [$];
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_stream(input int i, input int len, input int hold);
        slen[i]  = len;
        sidx[i]  = 0;
        shold[i] = hold;
        sen[i]   = 1'b1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (sen[i] && (sidx[i] < slen[i])) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = sdat[i][sidx[i]];
                last[i]        = slast[i][sidx[i]];
            end else begin
                req[i]  = 1'b0;
                last[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        s_load   = tx_load;  s_din  = tx_din;  s_ack  = ack;
        s_active = active;   s_cur  = cur_id;  s_err  = tx_err;
        s_load2  = tx_load2; s_din2 = tx_din2; s_ack2 = ack2;
        if (tx_load) begin
            if (n_lg < 32) lg[n_lg] = tx_din;
            n_lg++;
            if (tx_busy) n_viol++;
        end
        if ((ack != 4'b0) && !tx_load) n_viol++;
        for (int i = 0; i < 4; i++) if (ack[i]) ackc[i]++;
        if (tx_load2) begin
            if (n_lg2 < 32) lg2[n_lg2] = tx_din2;
            n_lg2++;
        end
        if (ack2[1]) a2c++;
        @(posedge clk);
        #1;
        if (s_load && !dead) begin
            tx_busy = 1'b1; bcnt = 3;
        end else if (tx_busy) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end
        if (s_load2) begin
            tx_busy2 = 1'b1; bcnt2 = 3;
        end else if (tx_busy2) begin
            bcnt2--;
            if (bcnt2 == 0) tx_busy2 = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (s_ack[i]) begin
                sidx[i]++;
                if (sidx[i] == shold[i]) sen[i] = 1'b0;
            end
        end
        req2 = req2 & ~s_ack2;
        drive_reqs();
    endtask

    task automatic run_quiet(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!((req == 4'b0) && !s_active && !tx_busy) && (k < budget));
        chk({tag, " finished in budget"}, 32'(k < budget), 32'd1);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, " load count"}, n_lg, exq.size());
        for (int k = 0; k < exq.size() && k < n_lg; k++)
            chk($sformatf("%s byte[%0d]", tag, k), lg[k], exq[k]);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; data = '0; last = '0; tx_busy = 1'b0;
        req2 = '0; data2 = '0; last2 = '0; tx_busy2 = 1'b0;
        dead = 1'b0; bcnt = 0; bcnt2 = 0; n_lg = 0; n_lg2 = 0; a2c = 0;
        for (int i = 0; i < 4; i++) begin
            slen[i] = 0; sidx[i] = 0; shold[i] = -1; sen[i] = 1'b0; ackc[i] = 0;
        end

        // Reset values
        @(posedge clk); #1;
        chk("rst ack", ack, 4'b0);
        chk("rst tx_load", tx_load, 1'b0);
        chk("rst tx_din", tx_din, 8'hFF);
        chk("rst active", active, 1'b0);
        chk("rst cur_id", cur_id, 3'd0);
        chk("rst tx_err", tx_err, 1'b0);
        chk("rst tx_din2", tx_din2, 8'hFF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single packet with header from requester 2
        sdat[2][0] = 8'h55; slast[2][0] = 1'b0;
        sdat[2][1] = 8'h3C; slast[2][1] = 1'b1;
        set_stream(2, 2, -1);
        drive_reqs();
        step();
        chk("t1 idle no load", s_load, 1'b0);
        chk("t1 idle inactive", s_active, 1'b0);
        step();
        chk("t1 latency load", s_load, 1'b1);
        chk("t1 header byte", s_din, 8'hA2);
        chk("t1 header no ack", s_ack, 4'b0);
        chk("t1 cur_id", s_cur, 3'd2);
        chk("t1 active", s_active, 1'b1);
        run_quiet(60, "t1");
        exq = '{8'hA2, 8'h55, 8'h3C};
        chk_log("t1");
        chk("t1 ack count r2", ackc[2], 2);
        chk("t1 ack count r0", ackc[0], 0);
        chk("t1 active after end", s_active, 1'b0);
        chk("t1 cur_id held", s_cur, 3'd2);

        // Round-robin: ptr is 2, so requester 3 wins first
        n_lg = 0;
        sdat[0][0] = 8'h10; sdat[0][1] = 8'h11; sdat[0][2] = 8'h12;
        sdat[3][0] = 8'h30; sdat[3][1] = 8'h31; sdat[3][2] = 8'h32;
        for (int k = 0; k < 3; k++) begin slast[0][k] = 1'b1; slast[3][k] = 1'b1; end
        set_stream(0, 3, -1);
        set_stream(3, 3, -1);
        drive_reqs();
        run_quiet(200, "t2");
        exq = '{8'hA3, 8'h30, 8'hA0, 8'h10, 8'hA3, 8'h31,
                8'hA0, 8'h11, 8'hA3, 8'h32, 8'hA0, 8'h12};
        chk_log("t2");

        // Lock and gap: requester 1 drops req after its first byte
        n_lg = 0;
        for (int i = 0; i < 4; i++) ackc[i] = 0;
        sdat[1][0] = 8'h41; slast[1][0] = 1'b0;
        sdat[1][1] = 8'h42; slast[1][1] = 1'b1;
        sdat[0][0] = 8'h01; slast[0][0] = 1'b1;
        set_stream(1, 2, 1);
        set_stream(0, 1, -1);
        drive_reqs();
        repeat (20) step();
        chk("t3 gap loads", n_lg, 2);
        chk("t3 gap byte0", lg[0], 8'hA1);
        chk("t3 gap byte1", lg[1], 8'h41);
        chk("t3 gap cur_id", s_cur, 3'd1);
        chk("t3 gap active", s_active, 1'b1);
        chk("t3 gap no load", s_load, 1'b0);
        chk("t3 gap r0 not acked", ackc[0], 0);
        sen[1] = 1'b1;
        drive_reqs();
        run_quiet(100, "t3");
        exq = '{8'hA1, 8'h41, 8'h42, 8'hA0, 8'h01};
        chk_log("t3");

        // Busy timeout with a dead transmitter
        n_lg = 0;
        for (int i = 0; i < 4; i++) ackc[i] = 0;
        dead = 1'b1;
        sdat[2][0] = 8'h77; slast[2][0] = 1'b1;
        set_stream(2, 1, -1);
        drive_reqs();
        n = 0;
        do begin step(); n++; end while (!s_load && (n < 5));
        chk("t4 header load", s_din, 8'hA2);
        repeat (15) step();
        step();
        chk("t4 16th wait err", s_err, 1'b0);
        chk("t4 16th wait active", s_active, 1'b1);
        dead = 1'b0;
        step();
        chk("t4 err set", s_err, 1'b1);
        chk("t4 active cleared", s_active, 1'b0);
        chk("t4 no ack on abandon", ackc[2], 0);
        n_lg = 0;
        run_quiet(60, "t4");
        exq = '{8'hA2, 8'h77};
        chk_log("t4");
        chk("t4 err sticky", s_err, 1'b1);
        chk("t4 served ack", ackc[2], 1);

        // Reset during WAIT_DONE
        n_lg = 0;
        sdat[1][0] = 8'h5A; slast[1][0] = 1'b1;
        set_stream(1, 1, -1);
        drive_reqs();
        n = 0;
        do begin step(); n++; end while (!s_load && (n < 5));
        chk("t5 header load", s_din, 8'hA1);
        step();
        step();
        chk("t5 in wait_done active", s_active, 1'b1);
        chk("t5 in wait_done no load", s_load, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5 rst tx_load", tx_load, 1'b0);
        chk("t5 rst ack", ack, 4'b0);
        chk("t5 rst tx_din", tx_din, 8'hFF);
        chk("t5 rst active", active, 1'b0);
        chk("t5 rst cur_id", cur_id, 3'd0);
        chk("t5 rst tx_err", tx_err, 1'b0);
        tx_busy = 1'b0; bcnt = 0; tx_busy2 = 1'b0; bcnt2 = 0;
        n_lg = 0;
        sdat[0][0] = 8'h0A; slast[0][0] = 1'b1;
        set_stream(0, 1, -1);
        drive_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_quiet(100, "t5");
        exq = '{8'hA0, 8'h0A, 8'hA1, 8'h5A};
        chk_log("t5");

        // Header disabled: single byte, ack with the load
        n_lg2 = 0; a2c = 0;
        req2 = 4'b0010; data2 = 32'h0000_A500; last2 = 4'b0010;
        step();
        chk("t6 idle no load", s_load2, 1'b0);
        step();
        chk("t6 load", s_load2, 1'b1);
        chk("t6 byte", s_din2, 8'hA5);
        chk("t6 ack same cycle", s_ack2, 4'b0010);
        repeat (10) step();
        chk("t6 single load", n_lg2, 1);
        chk("t6 single ack", a2c, 1);

        chk("load while busy or stray ack", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
